// File: rtl/handball_pkg.sv
// Shared types and constants for the handball display sequencer.
// The period shrink step is used only when HANDBALL_SPEEDUP_EN is defined.
package handball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_MOVE_R,
        ST_MOVE_L,
        ST_MISS,
        ST_OVER
    } state_t;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [7:0] BALL_L = 8'h80;
    localparam logic [7:0] BALL_R = 8'h01;

    // An eighth of the base period, but never zero so short periods still shrink.
    function automatic logic [15:0] speedup_step(input logic [15:0] div);
        logic [15:0] s;
        s = div >> 3;
        speedup_step = (s == 16'd0) ? 16'd1 : s;
    endfunction

endpackage

// File: rtl/handball_tick_gen.sv
// Ball step period counter: counts 0..period-1 and pulses tick on the last count.
// A restart forces the count back to 0 so a fresh serve gets a full first period.
module handball_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [15:0] period,
    output logic        tick
);

    logic [15:0] cnt;

    // >= keeps the counter bounded if the period shrinks below the current count
    assign tick = (cnt >= period - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= 16'd0;
        end else if (tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/handball_ctrl.sv
// Handball game sequencer: drives the 8-bit bidirectional shift register ball display.
// Optional feature macro: HANDBALL_SPEEDUP_EN (returns shorten the step period).
module handball_ctrl
    import handball_pkg::*;
#(
    parameter logic [15:0] TICK_DIV  = 16'd50000,
    parameter logic [15:0] MIN_DIV   = 16'd12500,
    parameter logic [3:0]  WIN_SCORE = 4'd9
) (
    input  logic       CK,
    input  logic       CLEAR,
    input  logic       START,
    input  logic       PL,
    input  logic       PR,
    input  logic [7:0] SROUT,
    output logic [1:0] SEL,
    output logic [7:0] SRIN,
    output logic       SIL,
    output logic       SIR,
    output logic       SR_CLEAR_N,
    output logic [3:0] SCORE_L,
    output logic [3:0] SCORE_R,
    output logic       GAME_OVER
);

    state_t      state, state_n;
    logic [1:0]  sel_n;
    logic [7:0]  srin_n;
    logic        clr_n_n;
    logic [3:0]  score_l_n, score_r_n;
    logic        over_n;
    logic        srv_left, srv_left_n;
    logic        pt_left, pt_left_n;
    logic        hit_l, hit_r, hit_l_n, hit_r_n;
    logic        start_q, pl_q, pr_q;
    logic        start_e, pl_e, pr_e;
    logic        hl, hr;
    logic        restart, ret, tick;
    logic [3:0]  cur_score, new_score;
    logic [15:0] period;

    assign SIL = 1'b0;
    assign SIR = 1'b0;

    assign start_e = START & ~start_q;
    assign pl_e    = PL & ~pl_q;
    assign pr_e    = PR & ~pr_q;

    handball_tick_gen u_tick (
        .clk    (CK),
        .rst    (CLEAR),
        .restart(restart),
        .period (period),
        .tick   (tick)
    );

`ifdef HANDBALL_SPEEDUP_EN
    localparam logic [15:0] STEP = speedup_step(TICK_DIV);
    logic [15:0] period_n;

    always_comb begin
        period_n = period;
        if (restart) begin
            period_n = TICK_DIV;
        end else if (ret) begin
            period_n = (period >= MIN_DIV + STEP) ? period - STEP : MIN_DIV;
        end
    end

    always_ff @(posedge CK) begin
        if (CLEAR) begin
            period <= TICK_DIV;
        end else begin
            period <= period_n;
        end
    end
`else
    logic unused_cfg;
    assign period     = TICK_DIV;
    assign unused_cfg = ret ^ (^MIN_DIV);
`endif

    always_comb begin
        state_n    = state;
        sel_n      = SEL_HOLD;
        srin_n     = SRIN;
        clr_n_n    = 1'b1;
        score_l_n  = SCORE_L;
        score_r_n  = SCORE_R;
        over_n     = GAME_OVER;
        srv_left_n = srv_left;
        pt_left_n  = pt_left;
        hit_l_n    = hit_l;
        hit_r_n    = hit_r;
        restart    = 1'b0;
        ret        = 1'b0;
        hl         = hit_l | (pl_e && SROUT == BALL_L);
        hr         = hit_r | (pr_e && SROUT == BALL_R);
        cur_score  = pt_left ? SCORE_L : SCORE_R;
        new_score  = (cur_score < WIN_SCORE) ? cur_score + 4'd1 : cur_score;

        // Presses only count while the ball sits on that player's end
        if (state == ST_MOVE_R || state == ST_MOVE_L) begin
            if (pl_e && SROUT == BALL_L) hit_l_n = 1'b1;
            if (pr_e && SROUT == BALL_R) hit_r_n = 1'b1;
        end
        if (tick) begin
            hit_l_n = 1'b0;
            hit_r_n = 1'b0;
        end

        unique case (state)
            ST_IDLE: begin
                if (start_e) begin
                    sel_n      = SEL_LOAD;
                    srin_n     = BALL_L;
                    srv_left_n = 1'b1;
                    state_n    = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (srv_left && pl_e) begin
                    state_n = ST_MOVE_R;
                    restart = 1'b1;
                end else if (!srv_left && pr_e) begin
                    state_n = ST_MOVE_L;
                    restart = 1'b1;
                end
                if (restart) begin
                    hit_l_n = 1'b0;
                    hit_r_n = 1'b0;
                end
            end
            ST_MOVE_R: begin
                if (tick) begin
                    if (SROUT == BALL_R && hr) begin
                        sel_n   = SEL_SHL;
                        state_n = ST_MOVE_L;
                        ret     = 1'b1;
                    end else if (SROUT == BALL_R || SROUT == 8'h00) begin
                        clr_n_n   = 1'b0;
                        pt_left_n = 1'b1;
                        state_n   = ST_MISS;
                    end else begin
                        sel_n = SEL_SHR;
                    end
                end
            end
            ST_MOVE_L: begin
                if (tick) begin
                    if (SROUT == BALL_L && hl) begin
                        sel_n   = SEL_SHR;
                        state_n = ST_MOVE_R;
                        ret     = 1'b1;
                    end else if (SROUT == BALL_L || SROUT == 8'h00) begin
                        clr_n_n   = 1'b0;
                        pt_left_n = 1'b0;
                        state_n   = ST_MISS;
                    end else begin
                        sel_n = SEL_SHL;
                    end
                end
            end
            ST_MISS: begin
                if (pt_left) score_l_n = new_score;
                else         score_r_n = new_score;
                if (new_score == WIN_SCORE) begin
                    over_n  = 1'b1;
                    state_n = ST_OVER;
                end else begin
                    // The player who missed serves the next ball
                    sel_n      = SEL_LOAD;
                    srin_n     = pt_left ? BALL_R : BALL_L;
                    srv_left_n = ~pt_left;
                    state_n    = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_e) begin
                    score_l_n  = 4'd0;
                    score_r_n  = 4'd0;
                    over_n     = 1'b0;
                    sel_n      = SEL_LOAD;
                    srin_n     = BALL_L;
                    srv_left_n = 1'b1;
                    state_n    = ST_SERVE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (CLEAR) begin
            state      <= ST_IDLE;
            SEL        <= SEL_HOLD;
            SRIN       <= 8'h00;
            SR_CLEAR_N <= 1'b0;
            SCORE_L    <= 4'd0;
            SCORE_R    <= 4'd0;
            GAME_OVER  <= 1'b0;
            srv_left   <= 1'b1;
            pt_left    <= 1'b0;
            hit_l      <= 1'b0;
            hit_r      <= 1'b0;
            start_q    <= 1'b0;
            pl_q       <= 1'b0;
            pr_q       <= 1'b0;
        end else begin
            state      <= state_n;
            SEL        <= sel_n;
            SRIN       <= srin_n;
            SR_CLEAR_N <= clr_n_n;
            SCORE_L    <= score_l_n;
            SCORE_R    <= score_r_n;
            GAME_OVER  <= over_n;
            srv_left   <= srv_left_n;
            pt_left    <= pt_left_n;
            hit_l      <= hit_l_n;
            hit_r      <= hit_r_n;
            start_q    <= START;
            pl_q       <= PL;
            pr_q       <= PR;
        end
    end

endmodule
